ssd_scan_ctrl: RTL and testbench
================================

# ssd_scan_ctrl

Time-multiplexing scan controller that shares one combinational seven-segment decoder among NUM_DIGITS display digits. It holds one 4-bit code per digit, presents them to the decoder one slot at a time, and drives active-low per-digit anode enables. A blanking gap between slots prevents ghosting. It sits between the counter/datapath logic that produces digit codes and the board-level display pins.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (legal 1..8)
- REFRESH_DIV, 50000, clock cycles per digit slot (must exceed BLANK_CYCLES)
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off (legal ≥1)
- clk  input  1  single system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- load  input  1  one-cycle strobe: capture digits_in / digit_en_in
- digits_in  input  4*NUM_DIGITS  digit codes, digit i in bits [4i+3:4i]
- digit_en_in  input  NUM_DIGITS  per-digit enable; 0 keeps that anode off
- count_out  output  4  code driven to the shared decoder
- anode_n  output  NUM_DIGITS  active-low digit enables, at most one low
- frame_done  output  1  one-cycle pulse in the last cycle of the last slot

## Operation
- Reset values: count_out = BLANK_CODE (4'd0, decodes to all segments off), anode_n = all 1, frame_done = 0, slot index = 0, state = BLANK, slot counter = 0, digit and enable registers = 0, pending flag = 0.
- FSM states: BLANK, SHOW.
  - BLANK: anode_n all 1, count_out = BLANK_CODE; after BLANK_CYCLES cycles → SHOW.
  - SHOW: count_out = active code[idx]; anode_n[idx] = ~active_en[idx], others 1; after REFRESH_DIV−BLANK_CYCLES cycles → BLANK, idx advances.
- idx wraps NUM_DIGITS−1 → 0 (frame boundary). NUM_DIGITS=1 wraps every slot.
- Disabled digit: slot timing unchanged, anode stays high, count_out still carries the code.
- Codes are passed through unmodified; the decoder blanks any code it does not display.
- Reset asserted mid-slot: all state returns to reset values on the next edge; pending loads are discarded.

## Timing
- All outputs registered; a state/idx change is visible the cycle after the terminal count.
- Slot = exactly REFRESH_DIV cycles; frame = NUM_DIGITS*REFRESH_DIV cycles.
- First cycle after reset release is BLANK cycle 0 of slot 0.
- frame_done high for exactly one cycle, coinciding with the final SHOW cycle of slot NUM_DIGITS−1.
- load latency, see Configuration. load held high for several cycles: each cycle captures, last one wins.

## Configuration
- SSD_SCAN_SHADOW_EN defined: load writes shadow registers and sets pending; at the frame boundary (transition into slot 0 BLANK) the shadow is copied to the active registers and pending clears. load in the same cycle as the boundary transition: the new inputs go straight to the active registers for the new frame. No mid-frame tearing.
- Not defined: no shadow; load writes the active registers directly, visible from the next cycle (current slot updates mid-slot).

## Structure
- Package ssd_scan_pkg: BLANK_CODE = 4'd0, state enum typedef (BLANK, SHOW), digit code typedef logic [3:0].
- Sub-module ssd_slot_timer: slot cycle counter producing blank_done and slot_done terminal-count strobes from BLANK_CYCLES/REFRESH_DIV; FSM, index and registers stay in ssd_scan_ctrl.
- Counter width $clog2(REFRESH_DIV); index width max(1, $clog2(NUM_DIGITS)).

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset, then load digits_in=16'hFA95, digit_en_in=4'hF → per slot 2 cycles anode_n=4'hF/count_out=0, then 6 cycles anode_n=4'hE,D,B,7 with count_out=5,9,A,F; frame_done pulses at cycle 31 of each frame.
- digit_en_in=4'b1010 → slots 0 and 2 keep anode_n=4'hF throughout; slots 1/3 show normally; slot timing unchanged.
- Shadow build: load 16'h7777 during slot 1 → display continues with old codes until slot 0 of next frame, then 7 on all digits. Non-shadow build: count_out=7 on the next cycle.
- load asserted on the frame-boundary cycle (shadow build) → new codes shown in slot 0 of the immediately following frame.
- rst asserted during SHOW of slot 2 → next cycle anode_n=4'hF, count_out=0, frame_done=0, registers cleared; after release the scan restarts at slot 0 BLANK.
- NUM_DIGITS=1 → anode_n toggles 1/0 every 2/6 cycles, frame_done every 8 cycles.

Source files
------------

// File: rtl/ssd_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package ssd_scan_pkg;

    localparam logic [3:0] BLANK_CODE = 4'd0;

    typedef logic [3:0] digit_code_t;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Digit-code load port and display-side outputs of the scan controller.
interface ssd_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    import ssd_scan_pkg::*;

    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   digit_en_in;
    digit_code_t             count_out;
    logic [NUM_DIGITS-1:0]   anode_n;
    logic                    frame_done;

    modport master (
        output load, digits_in, digit_en_in,
        input  count_out, anode_n, frame_done
    );

    modport slave (
        input  load, digits_in, digit_en_in,
        output count_out, anode_n, frame_done
    );

endinterface

// File: rtl/ssd_slot_timer.sv
// Slot cycle counter: terminal-count strobes for the blanking gap, the
// second-to-last slot cycle and the last slot cycle.
module ssd_slot_timer #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    output logic blank_done,
    output logic slot_pre_done,
    output logic slot_done
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_PRE   = CNT_W'(REFRESH_DIV - 2);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    // Position within the current slot, restarting at every slot boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r == SLOT_LAST) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign blank_done    = (cnt_r == BLANK_LAST);
    assign slot_pre_done = (cnt_r == SLOT_PRE);
    assign slot_done     = (cnt_r == SLOT_LAST);

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with blanking gap.
// Optional SSD_SCAN_SHADOW_EN: loads are held in a shadow until the frame boundary.
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input logic            clk,
    input logic            rst,
    ssd_scan_ctrl_if.slave bus
);
    import ssd_scan_pkg::*;

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW    = 4 * NUM_DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic                  blank_done_s;
    logic                  slot_pre_done_s;
    logic                  slot_done_s;
    scan_state_t           state_r;
    logic [IDX_W-1:0]      idx_r;
    logic [DW-1:0]         digits_r;
    logic [NUM_DIGITS-1:0] en_r;
    logic [DW-1:0]         digits_nxt_s;
    logic [NUM_DIGITS-1:0] en_nxt_s;
    digit_code_t           count_out_r;
    logic [NUM_DIGITS-1:0] anode_n_r;
    logic                  frame_done_r;

    function automatic digit_code_t code_of(input logic [DW-1:0] d, input logic [IDX_W-1:0] sel);
        digit_code_t c;
        c = BLANK_CODE;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            c = c | (d[4*i +: 4] & {4{sel == IDX_W'(i)}});
        end
        return c;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] anode_of(input logic [NUM_DIGITS-1:0] en, input logic [IDX_W-1:0] sel);
        logic [NUM_DIGITS-1:0] a;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            a[i] = ~(en[i] & (sel == IDX_W'(i)));
        end
        return a;
    endfunction

    ssd_slot_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .blank_done    (blank_done_s),
        .slot_pre_done (slot_pre_done_s),
        .slot_done     (slot_done_s)
    );

`ifdef SSD_SCAN_SHADOW_EN
    logic [DW-1:0]         shadow_digits_r;
    logic [NUM_DIGITS-1:0] shadow_en_r;
    logic                  pending_r;
    logic                  frame_wrap_s;

    assign frame_wrap_s = (state_r == ST_SHOW) && slot_done_s && (idx_r == LAST_IDX);

    // Active codes change only at the frame boundary; a load on that very edge wins over the shadow
    always_comb begin
        digits_nxt_s = digits_r;
        en_nxt_s     = en_r;
        if (frame_wrap_s && bus.load) begin
            digits_nxt_s = bus.digits_in;
            en_nxt_s     = bus.digit_en_in;
        end else if (frame_wrap_s && pending_r) begin
            digits_nxt_s = shadow_digits_r;
            en_nxt_s     = shadow_en_r;
        end else begin
            digits_nxt_s = digits_r;
            en_nxt_s     = en_r;
        end
    end

    // Shadow capture and pending flag
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_digits_r <= {DW{1'b0}};
            shadow_en_r     <= {NUM_DIGITS{1'b0}};
            pending_r       <= 1'b0;
        end else if (frame_wrap_s) begin
            pending_r       <= 1'b0;
        end else if (bus.load) begin
            shadow_digits_r <= bus.digits_in;
            shadow_en_r     <= bus.digit_en_in;
            pending_r       <= 1'b1;
        end
    end
`else
    // Loads go straight to the active codes, so the current slot updates mid-slot
    always_comb begin
        digits_nxt_s = digits_r;
        en_nxt_s     = en_r;
        if (bus.load) begin
            digits_nxt_s = bus.digits_in;
            en_nxt_s     = bus.digit_en_in;
        end else begin
            digits_nxt_s = digits_r;
            en_nxt_s     = en_r;
        end
    end
`endif

    // Scan FSM; outputs are computed from next-cycle codes so a load shows one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_BLANK;
            idx_r        <= {IDX_W{1'b0}};
            digits_r     <= {DW{1'b0}};
            en_r         <= {NUM_DIGITS{1'b0}};
            count_out_r  <= BLANK_CODE;
            anode_n_r    <= {NUM_DIGITS{1'b1}};
            frame_done_r <= 1'b0;
        end else begin
            digits_r     <= digits_nxt_s;
            en_r         <= en_nxt_s;
            frame_done_r <= slot_pre_done_s && (idx_r == LAST_IDX);
            case (state_r)
                ST_BLANK: begin
                    if (blank_done_s) begin
                        state_r     <= ST_SHOW;
                        count_out_r <= code_of(digits_nxt_s, idx_r);
                        anode_n_r   <= anode_of(en_nxt_s, idx_r);
                    end else begin
                        count_out_r <= BLANK_CODE;
                        anode_n_r   <= {NUM_DIGITS{1'b1}};
                    end
                end
                ST_SHOW: begin
                    if (slot_done_s) begin
                        state_r     <= ST_BLANK;
                        idx_r       <= (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
                        count_out_r <= BLANK_CODE;
                        anode_n_r   <= {NUM_DIGITS{1'b1}};
                    end else begin
                        count_out_r <= code_of(digits_nxt_s, idx_r);
                        anode_n_r   <= anode_of(en_nxt_s, idx_r);
                    end
                end
                default: begin
                    state_r     <= ST_BLANK;
                    idx_r       <= {IDX_W{1'b0}};
                    count_out_r <= BLANK_CODE;
                    anode_n_r   <= {NUM_DIGITS{1'b1}};
                end
            endcase
        end
    end

    assign bus.count_out  = count_out_r;
    assign bus.anode_n    = anode_n_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Randomized self-checking bench for ssd_scan_ctrl (4-digit and 1-digit instances)
// against a cycle-index reference model; honours SSD_SCAN_SHADOW_EN.
module tb_ssd_scan_ctrl;
    localparam int RD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld4 = 1'b0;
    logic [15:0] din4 = 16'h0000;
    logic [3:0]  en4 = 4'h0;
    logic        ld1 = 1'b0;
    logic [3:0]  din1 = 4'h0;
    logic        en1 = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model state per instance: cycle index since reset and code registers
    int          nd [2];
    int          mt [2];
    logic [15:0] mc [2];
    logic [15:0] msh [2];
    logic [3:0]  me [2];
    logic [3:0]  mshe [2];
    bit          mp [2];
    logic [3:0]  exp_c [2];
    logic [3:0]  exp_a [2];
    logic        exp_f [2];

    ssd_scan_ctrl_if #(.NUM_DIGITS(4)) bus4 ();
    ssd_scan_ctrl_if #(.NUM_DIGITS(1)) bus1 ();

    assign bus4.load        = ld4;
    assign bus4.digits_in   = din4;
    assign bus4.digit_en_in = en4;
    assign bus1.load        = ld1;
    assign bus1.digits_in   = din1;
    assign bus1.digit_en_in = en1;

    ssd_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    ssd_scan_ctrl #(.NUM_DIGITS(1), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    task automatic model_step(input int d);
        bit          l;
        bit          boundary;
        logic [15:0] di;
        logic [3:0]  ei;
        int          pos;
        int          slot;
        int          frame;
        l     = (d == 0) ? ld4 : ld1;
        di    = (d == 0) ? din4 : {12'h000, din1};
        ei    = (d == 0) ? en4 : {3'b000, en1};
        frame = nd[d] * RD;
        if (rst) begin
            mt[d] = 0; mc[d] = 16'h0; me[d] = 4'h0; msh[d] = 16'h0; mshe[d] = 4'h0; mp[d] = 1'b0;
        end else begin
            boundary = ((mt[d] % frame) == frame - 1);
            mt[d]++;
`ifdef SSD_SCAN_SHADOW_EN
            if (l && boundary) begin
                mc[d] = di; me[d] = ei; mp[d] = 1'b0;
            end else if (l) begin
                msh[d] = di; mshe[d] = ei; mp[d] = 1'b1;
            end else if (boundary && mp[d]) begin
                mc[d] = msh[d]; me[d] = mshe[d]; mp[d] = 1'b0;
            end
`else
            if (l) begin
                mc[d] = di; me[d] = ei;
            end
`endif
        end
        pos  = mt[d] % RD;
        slot = (mt[d] / RD) % nd[d];
        exp_c[d] = 4'h0;
        exp_a[d] = 4'hF;
        if (pos >= BC) begin
            exp_c[d] = mc[d][slot*4 +: 4];
            if (me[d][slot]) exp_a[d][slot] = 1'b0;
        end
        exp_f[d] = ((mt[d] % frame) == frame - 1);
    endtask

    // One clock: advance the model on the edge, then settle to the falling edge
    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic test_reset();
        ld4 = 1'b0; ld1 = 1'b0; rst = 1'b1;
        tick(); tick();
        checks++;
        if ({bus4.count_out, bus4.anode_n, bus4.frame_done} !== {4'h0, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL reset4: got cnt=%h an=%b fd=%b, want cnt=0 an=1111 fd=0", bus4.count_out, bus4.anode_n, bus4.frame_done);
        end
        checks++;
        if ({bus1.count_out, bus1.anode_n, bus1.frame_done} !== {4'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset1: got cnt=%h an=%b fd=%b, want cnt=0 an=1 fd=0", bus1.count_out, bus1.anode_n, bus1.frame_done);
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if ({bus4.count_out, bus4.anode_n, bus4.frame_done} !== {exp_c[0], exp_a[0], exp_f[0]}) begin
                errors++;
                $display("FAIL post_reset4 t=%0d: got %h/%b/%b want %h/%b/%b", mt[0], bus4.count_out, bus4.anode_n, bus4.frame_done, exp_c[0], exp_a[0], exp_f[0]);
            end
        end
    endtask

    task automatic test_full_enable();
        din4 = 16'hFA95; en4 = 4'hF; ld4 = 1'b1;
        din1 = 4'h5; en1 = 1'b1; ld1 = 1'b1;
        tick();
        ld4 = 1'b0; ld1 = 1'b0;
        for (int k = 0; k < 96; k++) begin
            tick();
            checks++;
            if ({bus4.count_out, bus4.anode_n, bus4.frame_done} !== {exp_c[0], exp_a[0], exp_f[0]}) begin
                errors++;
                $display("FAIL full_en4 t=%0d: got %h/%b/%b want %h/%b/%b", mt[0], bus4.count_out, bus4.anode_n, bus4.frame_done, exp_c[0], exp_a[0], exp_f[0]);
            end
            checks++;
            if ({bus1.count_out, bus1.anode_n, bus1.frame_done} !== {exp_c[1], exp_a[1][0], exp_f[1]}) begin
                errors++;
                $display("FAIL full_en1 t=%0d: got %h/%b/%b want %h/%b/%b", mt[1], bus1.count_out, bus1.anode_n, bus1.frame_done, exp_c[1], exp_a[1][0], exp_f[1]);
            end
        end
    endtask

    task automatic test_enable_mask();
        din4 = 16'hFA95; en4 = 4'b1010; ld4 = 1'b1;
        tick();
        ld4 = 1'b0;
        for (int k = 0; k < 80; k++) begin
            tick();
            checks++;
            if ({bus4.count_out, bus4.anode_n, bus4.frame_done} !== {exp_c[0], exp_a[0], exp_f[0]}) begin
                errors++;
                $display("FAIL en_mask t=%0d: got %h/%b/%b want %h/%b/%b", mt[0], bus4.count_out, bus4.anode_n, bus4.frame_done, exp_c[0], exp_a[0], exp_f[0]);
            end
        end
    endtask

    task automatic test_load_mid_frame();
        for (int k = 0; k < 64 && (mt[0] % 32) != 10; k++) tick();
        din4 = 16'h7777; en4 = 4'hF; ld4 = 1'b1;
        tick();
        ld4 = 1'b0;
        checks++;
`ifdef SSD_SCAN_SHADOW_EN
        if (bus4.count_out !== 4'h9) begin
            errors++;
            $display("FAIL mid_load_immediate: got cnt=%h want 9", bus4.count_out);
        end
`else
        if (bus4.count_out !== 4'h7) begin
            errors++;
            $display("FAIL mid_load_immediate: got cnt=%h want 7", bus4.count_out);
        end
`endif
        for (int k = 0; k < 64; k++) begin
            tick();
            checks++;
            if ({bus4.count_out, bus4.anode_n, bus4.frame_done} !== {exp_c[0], exp_a[0], exp_f[0]}) begin
                errors++;
                $display("FAIL mid_load t=%0d: got %h/%b/%b want %h/%b/%b", mt[0], bus4.count_out, bus4.anode_n, bus4.frame_done, exp_c[0], exp_a[0], exp_f[0]);
            end
        end
    endtask

    task automatic test_boundary_load();
        for (int k = 0; k < 64 && (mt[0] % 32) != 31; k++) tick();
        din4 = 16'($urandom); en4 = 4'($urandom); ld4 = 1'b1;
        din1 = 4'($urandom); en1 = 1'b1; ld1 = 1'b1;
        tick();
        ld4 = 1'b0; ld1 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            checks++;
            if ({bus4.count_out, bus4.anode_n, bus4.frame_done} !== {exp_c[0], exp_a[0], exp_f[0]}) begin
                errors++;
                $display("FAIL boundary4 t=%0d: got %h/%b/%b want %h/%b/%b", mt[0], bus4.count_out, bus4.anode_n, bus4.frame_done, exp_c[0], exp_a[0], exp_f[0]);
            end
            checks++;
            if ({bus1.count_out, bus1.anode_n, bus1.frame_done} !== {exp_c[1], exp_a[1][0], exp_f[1]}) begin
                errors++;
                $display("FAIL boundary1 t=%0d: got %h/%b/%b want %h/%b/%b", mt[1], bus1.count_out, bus1.anode_n, bus1.frame_done, exp_c[1], exp_a[1][0], exp_f[1]);
            end
        end
    endtask

    task automatic test_random_loads();
        for (int k = 0; k < 400; k++) begin
            ld4 = ($urandom_range(0, 7) == 0); din4 = 16'($urandom); en4 = 4'($urandom);
            ld1 = ($urandom_range(0, 5) == 0); din1 = 4'($urandom); en1 = 1'($urandom);
            tick();
            checks++;
            if ({bus4.count_out, bus4.anode_n, bus4.frame_done} !== {exp_c[0], exp_a[0], exp_f[0]}) begin
                errors++;
                $display("FAIL random4 t=%0d: got %h/%b/%b want %h/%b/%b", mt[0], bus4.count_out, bus4.anode_n, bus4.frame_done, exp_c[0], exp_a[0], exp_f[0]);
            end
            checks++;
            if ({bus1.count_out, bus1.anode_n, bus1.frame_done} !== {exp_c[1], exp_a[1][0], exp_f[1]}) begin
                errors++;
                $display("FAIL random1 t=%0d: got %h/%b/%b want %h/%b/%b", mt[1], bus1.count_out, bus1.anode_n, bus1.frame_done, exp_c[1], exp_a[1][0], exp_f[1]);
            end
        end
        ld4 = 1'b0; ld1 = 1'b0;
    endtask

    task automatic test_reset_mid_slot();
        for (int k = 0; k < 64 && (mt[0] % 32) != 18; k++) tick();
        din4 = 16'h3C3C; en4 = 4'hF; ld4 = 1'b1;
        tick();
        ld4 = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus4.count_out, bus4.anode_n, bus4.frame_done} !== {4'h0, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got cnt=%h an=%b fd=%b, want cnt=0 an=1111 fd=0", bus4.count_out, bus4.anode_n, bus4.frame_done);
        end
        for (int k = 0; k < 48; k++) begin
            tick();
            checks++;
            if ({bus4.count_out, bus4.anode_n, bus4.frame_done} !== {exp_c[0], exp_a[0], exp_f[0]}) begin
                errors++;
                $display("FAIL after_reset t=%0d: got %h/%b/%b want %h/%b/%b", mt[0], bus4.count_out, bus4.anode_n, bus4.frame_done, exp_c[0], exp_a[0], exp_f[0]);
            end
        end
    endtask

    initial begin
        nd[0] = 4;
        nd[1] = 1;
        for (int d = 0; d < 2; d++) begin
            mt[d] = 0; mc[d] = 16'h0; me[d] = 4'h0; msh[d] = 16'h0; mshe[d] = 4'h0; mp[d] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_full_enable();
        test_enable_mask();
        test_load_mid_frame();
        test_boundary_load();
        test_random_loads();
        test_reset_mid_slot();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
